alu_arbiter: RTL

Shares the single 8-bit ALU datapath (ops 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl1, 110 shr1, 111 slt) between NUM_REQ independent requesters. The block accepts one operation at a time using a round-robin grant, drives the ALU's op/operand inputs from registers, and captures result and zero flag. It returns them on a single tagged response channel with backpressure. It sits between the requesting units (fetch/decode, address-gen, etc.) and the ALU instance.

---
 rtl/alu_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU among NUM_REQ requesters; ALU_ARB_FIXED_PRIO_EN selects fixed priority.
// Latency: accept edge T, ALU evaluates in cycle T+1, rsp_valid from cycle T+2; one op in flight at a time.
// Backpressure: response held stable while rsp_ready is low; no request accepted until the response is taken.
module alu_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [3*NUM_REQ-1:0] req_op,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic [2:0]           alu_op,
    output logic [7:0]           alu_r0,
    output logic [7:0]           alu_r1,
    input  logic [7:0]           alu_result,
    input  logic                 alu_zero,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_result,
    output logic                 rsp_zero,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic            win_vld;
    logic [ID_W-1:0] win_idx;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Scan downward so the lowest-indexed valid requester is the last write.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                win_vld = 1'b1;
                win_idx = ID_W'(k);
            end
        end
    end
`else
    logic [ID_W-1:0] ptr;

    // Same downward scan, but over positions relative to ptr so the nearest one at/after ptr wins.
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[idx]) begin
                win_vld = 1'b1;
                win_idx = ID_W'(idx);
            end
        end
    end
`endif

    assign req_ready = (state == IDLE && win_vld) ? (NUM_REQ'(1) << win_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_op     <= '0;
            alu_r0     <= '0;
            alu_r1     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            busy       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        alu_op <= req_op[3*win_idx +: 3];
                        alu_r0 <= req_a[8*win_idx +: 8];
                        alu_r1 <= req_b[8*win_idx +: 8];
                        rsp_id <= win_idx;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        ptr    <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
